// File: rtl/cmn_stream_demux_n_pkg.sv
// Shared types for the stream demultiplexer and its per-lane 2-entry queue.
package cmn_stream_demux_n_pkg;

  // Occupancy of one lane queue; the encoding is the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/cmn_queue2_lane.sv
// Two-entry FIFO for one output lane. Output payload always comes from the head register,
// and enq_rdy depends only on the registered occupancy.
module cmn_queue2_lane
  import cmn_stream_demux_n_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  q_state_e           state, state_next;
  logic [p_nbits-1:0] head, tail;
  logic               head_from_enq, head_from_tail, tail_we;
  logic               enq_fire, deq_fire;

  assign enq_rdy  = (state != Q_FULL);
  assign deq_val  = (state != Q_EMPTY);
  assign deq_msg  = head;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_comb begin
    state_next     = state;
    head_from_enq  = 1'b0;
    head_from_tail = 1'b0;
    tail_we        = 1'b0;
    case (state)
      Q_EMPTY: begin
        if (enq_fire) begin
          head_from_enq = 1'b1;
          state_next    = Q_ONE;
        end
      end
      Q_ONE: begin
        // Simultaneous enq/deq replaces the head, keeping one entry.
        if (enq_fire && deq_fire) begin
          head_from_enq = 1'b1;
        end else if (enq_fire) begin
          tail_we    = 1'b1;
          state_next = Q_FULL;
        end else if (deq_fire) begin
          state_next = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (deq_fire) begin
          head_from_tail = 1'b1;
          state_next     = Q_ONE;
        end
      end
      default: state_next = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= Q_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      if (head_from_enq) begin
        head <= enq_msg;
      end else if (head_from_tail) begin
        head <= tail;
      end
      if (tail_we) begin
        tail <= enq_msg;
      end
    end
  end

endmodule

// File: rtl/cmn_stream_demux_n.sv
// Steers one val/rdy input stream to p_noutputs buffered output lanes by istream_sel;
// out-of-range selects are consumed, flagged on drop_pulse and counted in drop_count.
module cmn_stream_demux_n
  import cmn_stream_demux_n_pkg::*;
#(
  parameter  int p_nbits    = 8,
  parameter  int p_noutputs = 4,
  parameter  int p_cntbits  = 8,
  localparam int c_selbits  = $clog2(p_noutputs)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          istream_val,
  output logic                          istream_rdy,
  input  logic [p_nbits-1:0]            istream_msg,
  input  logic [c_selbits-1:0]          istream_sel,
  output logic [p_noutputs-1:0]         ostream_val,
  input  logic [p_noutputs-1:0]         ostream_rdy,
  output logic [p_noutputs*p_nbits-1:0] ostream_msg,
  output logic                          drop_pulse,
  output logic [p_cntbits-1:0]          drop_count
);

  // Handshake: a transfer happens on a posedge where val && rdy; a producer holding val
  // may not retract it, and rdy never depends combinationally on the same port's val.

  logic [p_noutputs-1:0] lane_enq_val, lane_enq_rdy, lane_deq_val;
  logic [p_nbits-1:0]    lane_deq_msg [p_noutputs];
  logic                  sel_ok, drop_fire;

  assign sel_ok    = ({1'b0, istream_sel} < (c_selbits+1)'(p_noutputs));
  assign drop_fire = istream_val && !sel_ok;

  // An unmatched select leaves istream_rdy high so the message is swallowed.
  always_comb begin
    lane_enq_val = '0;
    istream_rdy  = 1'b1;
    for (int i = 0; i < p_noutputs; i++) begin
      if (istream_sel == c_selbits'(i)) begin
        istream_rdy     = lane_enq_rdy[i];
        lane_enq_val[i] = istream_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop_fire;
      if (drop_fire && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < p_noutputs; g++) begin : g_lane
    cmn_queue2_lane #(
      .p_nbits (p_nbits)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .enq_val (lane_enq_val[g]),
      .enq_rdy (lane_enq_rdy[g]),
      .enq_msg (istream_msg),
      .deq_val (lane_deq_val[g]),
      .deq_rdy (ostream_rdy[p_noutputs-1-g]),
      .deq_msg (lane_deq_msg[g])
    );

    // Lane 0 occupies the most significant bits of the packed outputs.
    assign ostream_val[p_noutputs-1-g]                     = lane_deq_val[g];
    assign ostream_msg[(p_noutputs-1-g)*p_nbits +: p_nbits] = lane_deq_msg[g];
  end

endmodule

// File: tb/tb_cmn_stream_demux_n.sv
// Bench for cmn_stream_demux_n with 5 lanes: directed table, multi-cycle sequences and
// random traffic checked against a per-lane FIFO reference model.
module tb_cmn_stream_demux_n;

  localparam int NB = 8;
  localparam int NO = 5;
  localparam int SB = 3;
  localparam int CB = 8;

  logic             clk;
  logic             reset_n;
  logic             istream_val;
  logic             istream_rdy;
  logic [NB-1:0]    istream_msg;
  logic [SB-1:0]    istream_sel;
  logic [NO-1:0]    ostream_val;
  logic [NO-1:0]    ostream_rdy;
  logic [NO*NB-1:0] ostream_msg;
  logic             drop_pulse;
  logic [CB-1:0]    drop_count;

  cmn_stream_demux_n #(
    .p_nbits    (NB),
    .p_noutputs (NO),
    .p_cntbits  (CB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .istream_sel (istream_sel),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .drop_pulse  (drop_pulse),
    .drop_count  (drop_count)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Each lane is a list of at most two pending messages; element 0 is what the lane shows.
  logic [NB-1:0] mq [NO][2];
  int            mn [NO];
  int            m_cnt;
  logic          m_pulse;

  logic          cur_v;
  logic [SB-1:0] cur_s;
  logic [NB-1:0] cur_m;
  logic [NO-1:0] cur_r;
  logic          cur_exp_rdy;

  logic [NB-1:0] exp_q [$];

  task automatic model_clear();
    for (int i = 0; i < NO; i++) mn[i] = 0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, then compare every output against the model's view of the current cycle.
  task automatic drive_check(input logic v, input logic [SB-1:0] s, input logic [NB-1:0] m,
                             input logic [NO-1:0] r);
    logic [NO-1:0] eo;
    istream_val = v;
    istream_sel = s;
    istream_msg = m;
    ostream_rdy = r;
    #1;
    if (int'(s) >= NO) cur_exp_rdy = 1'b1;
    else               cur_exp_rdy = (mn[s] != 2);
    chk("istream_rdy", 32'(istream_rdy), 32'(cur_exp_rdy));
    eo = '0;
    for (int i = 0; i < NO; i++) eo[NO-1-i] = (mn[i] > 0);
    chk("ostream_val", 32'(ostream_val), 32'(eo));
    for (int i = 0; i < NO; i++) begin
      if (mn[i] > 0) chk("lane_msg", 32'(ostream_msg[(NO-1-i)*NB +: NB]), 32'(mq[i][0]));
    end
    chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
    chk("drop_count", 32'(drop_count), 32'(m_cnt));
    cur_v = v;
    cur_s = s;
    cur_m = m;
    cur_r = r;
  endtask

  // Advance one clock edge and apply the same transfers to the model.
  task automatic tick();
    logic in_fire;
    @(posedge clk);
    in_fire = cur_v && cur_exp_rdy;
    for (int i = 0; i < NO; i++) begin
      if (mn[i] > 0 && cur_r[NO-1-i]) begin
        mq[i][0] = mq[i][1];
        mn[i]    = mn[i] - 1;
      end
    end
    m_pulse = 1'b0;
    if (in_fire) begin
      if (int'(cur_s) < NO) begin
        mq[cur_s][mn[cur_s]] = cur_m;
        mn[cur_s]            = mn[cur_s] + 1;
      end else begin
        m_pulse = 1'b1;
        if (m_cnt < (1 << CB) - 1) m_cnt = m_cnt + 1;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic          v;
    logic [SB-1:0] s;
    logic [NB-1:0] m;
    logic [NO-1:0] r;
    logic          e_rdy;
    logic [NO-1:0] e_oval;
    logic [NB-1:0] e_msg;
    logic          e_pulse;
    logic [CB-1:0] e_cnt;
  } vec_t;

  localparam int NT = 18;
  vec_t tbl [NT];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    istream_val = 1'b1;
    istream_sel = '0;
    istream_msg = 8'hAA;
    ostream_rdy = '0;
    model_clear();

    //           v     s     m      r         rdy   oval      msg    pls   cnt
    tbl[0]  = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 3'd2, 8'hA5, 5'b00100, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 5'b00100, 1'b1, 5'b00100, 8'hA5, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 3'd0, 8'h11, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 3'd0, 8'h22, 5'b00000, 1'b1, 5'b10000, 8'h11, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 3'd0, 8'h33, 5'b00000, 1'b0, 5'b10000, 8'h11, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 3'd0, 8'h33, 5'b10000, 1'b0, 5'b10000, 8'h11, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 3'd0, 8'h33, 5'b10000, 1'b1, 5'b10000, 8'h22, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 5'b10000, 1'b1, 5'b10000, 8'h33, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[11] = '{1'b1, 3'd6, 8'hFF, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 3'd5, 8'h12, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b1, 8'd2};
    tbl[16] = '{1'b1, 3'd7, 8'h77, 5'b11111, 1'b1, 5'b00000, 8'h00, 1'b0, 8'd2};
    tbl[17] = '{1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, 5'b00000, 8'h00, 1'b1, 8'd3};

    // ---- reset held for 3 cycles with input valid ----
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst_oval", 32'(ostream_val), 32'd0);
      chk("rst_omsg", 32'(ostream_msg), 32'd0);
      chk("rst_cnt", 32'(drop_count), 32'd0);
      chk("rst_pulse", 32'(drop_pulse), 32'd0);
    end
    istream_val = 1'b0;
    reset_n     = 1'b1;
    model_clear();
    @(negedge clk);

    // ---- directed table: single route, backpressure, invalid selects ----
    for (int t = 0; t < NT; t++) begin
      drive_check(tbl[t].v, tbl[t].s, tbl[t].m, tbl[t].r);
      chk("tbl_rdy", 32'(istream_rdy), 32'(tbl[t].e_rdy));
      chk("tbl_oval", 32'(ostream_val), 32'(tbl[t].e_oval));
      for (int i = 0; i < NO; i++) begin
        if (tbl[t].e_oval[NO-1-i]) begin
          chk("tbl_msg", 32'(ostream_msg[(NO-1-i)*NB +: NB]), 32'(tbl[t].e_msg));
          break;
        end
      end
      chk("tbl_pulse", 32'(drop_pulse), 32'(tbl[t].e_pulse));
      chk("tbl_cnt", 32'(drop_count), 32'(tbl[t].e_cnt));
      tick();
    end

    // ---- full throughput into lane 4, 1-cycle latency, in order ----
    for (int k = 0; k < 100; k++) begin
      drive_check(1'b1, 3'd4, 8'(k), 5'b00001);
      chk("thru_rdy", 32'(istream_rdy), 32'd1);
      if (k > 0) chk("thru_seq", 32'(ostream_msg[NB-1:0]), 32'(exp_q.pop_front()));
      exp_q.push_back(8'(k));
      tick();
    end
    drive_check(1'b0, 3'd4, 8'h00, 5'b00001);
    chk("thru_last", 32'(ostream_msg[NB-1:0]), 32'(exp_q.pop_front()));
    tick();
    drive_check(1'b0, 3'd4, 8'h00, 5'b00001);
    chk("thru_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // ---- drop counter saturation ----
    for (int k = 0; k < 300; k++) begin
      drive_check(1'b1, 3'(5 + (k % 3)), 8'($urandom), 5'($urandom));
      tick();
    end
    drive_check(1'b0, 3'd0, 8'h00, 5'b00000);
    chk("sat_cnt", 32'(drop_count), 32'd255);
    chk("sat_pulse", 32'(drop_pulse), 32'd1);
    tick();

    // ---- mid-run asynchronous reset with lanes 1 and 3 full ----
    drive_check(1'b1, 3'd1, 8'h31, 5'b00000); tick();
    drive_check(1'b1, 3'd1, 8'h32, 5'b00000); tick();
    drive_check(1'b1, 3'd3, 8'h41, 5'b00000); tick();
    drive_check(1'b1, 3'd3, 8'h42, 5'b00000); tick();
    drive_check(1'b1, 3'd1, 8'h33, 5'b00000);
    chk("pre_rst_oval", 32'(ostream_val), 32'b01010);
    chk("pre_rst_full", 32'(istream_rdy), 32'd0);
    istream_val = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("async_oval", 32'(ostream_val), 32'd0);
    chk("async_cnt", 32'(drop_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    drive_check(1'b1, 3'd1, 8'h55, 5'b01000); tick();
    drive_check(1'b0, 3'd0, 8'h00, 5'b00000);
    chk("post_rst_msg", 32'(ostream_msg[3*NB +: NB]), 32'h55);
    tick();

    // ---- random traffic against the model ----
    for (int k = 0; k < 1500; k++) begin
      drive_check(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 5'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
